banked_mem: RTL and testbench
=============================

# banked_mem

Parametrised multi-bank single-port memory.
- Splits a flat address space across `NUM_BANKS` equal sub-banks selected by the address MSBs.
- Provides a fixed-latency read path with a valid strobe.
- Serves as the generalised successor of the two-bank 16x8 array used as the RTL side of vmem refinement checks.
- Intended as a drop-in DUT for ILA memory-instruction verification at arbitrary width, depth and bank count.

## Interface
Parameters:
- `DATA_W`, 8, data word width in bits.
- `ADDR_W`, 4, total address width; depth = 2^ADDR_W.
- `NUM_BANKS`, 2, power of two, 1 ≤ NUM_BANKS ≤ 2^ADDR_W.
- `READ_LAT`, 1, read latency in cycles, legal values 1 or 2. A value of 2 adds an output register.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `addr`  in  ADDR_W  word address, shared by read and write.
- `wdata`  in  DATA_W  write data.
- `wen`  in  1  write enable.
- `ren`  in  1  read enable.
- `rdata`  out  DATA_W  read data.
- `rvalid`  out  1  `rdata` carries the result of the read issued READ_LAT cycles earlier.

## Operation
- Bank index = `addr[ADDR_W-1 -: BANK_W]`, where `BANK_W = $clog2(NUM_BANKS)`. Sub-address = remaining low bits. When NUM_BANKS = 1, BANK_W is 0 and the whole address is the sub-address.
- Write: when `wen`=1, the selected bank stores `wdata` at the sub-address on the rising edge. Other banks are untouched.
- Read: when `ren`=1, only the selected bank is enabled. Its registered output is muxed by a bank index delayed to match the latency. Unselected banks hold their output registers.
- Only the addressed bank sees `wen`/`ren`. Unaddressed banks never change state.
- Read and write in the same cycle are legal; both use `addr`.
  - Default is read-first: `rdata` returns the pre-write contents.
- `rdata` holds its last value while `rvalid`=0.
- Memory contents are not reset. Reading a never-written location returns X in simulation. Benches must write before reading.
- Reset values: `rdata`=0, `rvalid`=0, delayed bank index=0, all read-pipeline valid bits=0.

## Timing
- `ren` at edge T → `rvalid`=1 with data during cycle T+READ_LAT. This is exactly one pulse per accepted read; there is no back-pressure.
- Back-to-back reads every cycle are supported. Throughput is one read per cycle across any bank sequence, including alternating banks.
- Writes take effect at the edge. A read issued at T+1 to the same address returns the new data.
- `rst` asserted at edge T:
  - Squashes all in-flight reads; `rvalid`=0 from T+1 until a post-reset `ren`.
  - A `wen` coincident with `rst` is ignored.
  - A `ren` coincident with `rst` is dropped.
- Address wrap: there is none. Every ADDR_W-bit value maps to exactly one bank location.

## Configuration
- `BANKED_MEM_WR_BYPASS_EN` defined: write-first behaviour. A same-cycle `wen`&`ren` to the same address returns `wdata` through a bypass register aligned to READ_LAT.
- Macro undefined: read-first, and no bypass logic is present.
- The macro affects only this collision case; all other behaviour is identical.

## Structure
- `banked_mem_pkg`:
  - `bank_idx()` and `sub_addr()` functions parametrised by ADDR_W and NUM_BANKS.
  - Legal `READ_LAT` constants.
  - An elaboration check that NUM_BANKS is a power of two.
- Sub-module `mem_bank`: a single bank of depth 2^(ADDR_W−BANK_W) with its own `wen`/`ren` and an output register. `banked_mem` instantiates NUM_BANKS copies in a generate loop.

## Test plan
- Reset then idle → `rvalid`=0 and `rdata`=0 for 10 cycles.
- Defaults: write 0xA5@0x3 and 0x5A@0xB, then read 0x3 at T and 0xB at T+1 → `rvalid` at T+1 and T+2 with 0xA5 then 0x5A. This proves bank-select alignment.
- `NUM_BANKS`=4, `ADDR_W`=6, `READ_LAT`=2: fill all 64 words with value = addr^0x3C, then read sequentially every cycle → 64 consecutive `rvalid` pulses with matching data, first pulse 2 cycles after the first `ren`.
- Collision: 0x11 stored at 0x7, then `wen`&`ren` @0x7 with `wdata`=0x22 → returns 0x11 without the macro, 0x22 with `BANKED_MEM_WR_BYPASS_EN`. A follow-up read returns 0x22 in both builds.
- A read issued, then `rst` at the next edge (`READ_LAT`=2) → no `rvalid` pulse appears.
- Write 0xFF@0x2 (bank 0), then read 0xA (bank 1, preloaded 0x00) → returns 0x00. This proves there is no cross-bank aliasing.

Source files
------------

// File: rtl/banked_mem_pkg.sv
// Shared helpers for banked_mem: address split functions, legal read latencies
// and the power-of-two check used at elaboration.
package banked_mem_pkg;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic int unsigned bank_idx(input int unsigned addr, input int addr_w,
                                           input int num_banks);
    int bw;
    bw = $clog2(num_banks);
    if (bw == 0) return 0;
    return addr >> (addr_w - bw);
  endfunction

  function automatic int unsigned sub_addr(input int unsigned addr, input int addr_w,
                                           input int num_banks);
    int bw;
    bw = $clog2(num_banks);
    return addr & ((32'd1 << (addr_w - bw)) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_bank.sv
// One single-port bank: unreset storage plus a read output register that
// only moves on its own ren, so idle banks hold their last read.
module mem_bank #(
  parameter int DATA_W = 8,
  parameter int AW     = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic              ren,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[addr] <= wdata;
  end

  // Read-first: the register captures the pre-write word on a collision.
  always_ff @(posedge clk) begin
    if (rst)      rdata <= '0;
    else if (ren) rdata <= mem[addr];
  end

endmodule

// File: rtl/banked_mem.sv
// Multi-bank single-port memory with fixed READ_LAT read path and rvalid strobe.
// Optional write-first collision bypass: BANKED_MEM_WR_BYPASS_EN.
module banked_mem
  import banked_mem_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int NUM_BANKS = 2,
  parameter int READ_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wen,
  input  logic              ren,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int BIDX_W = (BANK_W > 0) ? BANK_W : 1;
  localparam int SUB_W  = ADDR_W - BANK_W;
  localparam int SUB_AW = (SUB_W > 0) ? SUB_W : 1;

  if (!is_pow2(NUM_BANKS)) begin : g_bad_banks
    $error("banked_mem: NUM_BANKS must be a power of two");
  end
  if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
    $error("banked_mem: READ_LAT must be 1 or 2");
  end

  logic [BIDX_W-1:0]                  bidx, bsel_q;
  logic [SUB_AW-1:0]                  saddr;
  logic [NUM_BANKS-1:0]               bank_wen, bank_ren;
  logic [NUM_BANKS-1:0][DATA_W-1:0]   bank_rdata;
  logic [READ_LAT:1]                  vld_pipe;
  logic [DATA_W-1:0]                  rd_mux;

  assign bidx  = BIDX_W'(bank_idx(32'(addr), ADDR_W, NUM_BANKS));
  assign saddr = SUB_AW'(sub_addr(32'(addr), ADDR_W, NUM_BANKS));

  // Reset masks both strobes so a coincident access never reaches a bank.
  always_comb begin
    bank_wen = '0;
    bank_ren = '0;
    if (!rst) begin
      bank_wen[bidx] = wen;
      bank_ren[bidx] = ren;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_bank #(
      .DATA_W (DATA_W),
      .AW     (SUB_AW),
      .DEPTH  (2 ** SUB_W)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .wen   (bank_wen[b]),
      .ren   (bank_ren[b]),
      .addr  (saddr),
      .wdata (wdata),
      .rdata (bank_rdata[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      bsel_q   <= '0;
    end else begin
      vld_pipe[1] <= ren;
      for (int s = 2; s <= READ_LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
      if (ren) bsel_q <= bidx;
    end
  end

`ifdef BANKED_MEM_WR_BYPASS_EN
  // Shared addr means any wen&ren pair is a same-address collision.
  logic              byp_hit_q;
  logic [DATA_W-1:0] byp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else if (ren) begin
      byp_hit_q  <= wen;
      byp_data_q <= wdata;
    end
  end

  assign rd_mux = byp_hit_q ? byp_data_q : bank_rdata[bsel_q];
`else
  assign rd_mux = bank_rdata[bsel_q];
`endif

  if (READ_LAT == 2) begin : g_out_reg
    logic [DATA_W-1:0] rdata_q;
    always_ff @(posedge clk) begin
      if (rst)              rdata_q <= '0;
      else if (vld_pipe[1]) rdata_q <= rd_mux;
    end
    assign rdata = rdata_q;
  end else begin : g_out_comb
    assign rdata = rd_mux;
  end

  assign rvalid = vld_pipe[READ_LAT];

endmodule

// File: tb/tb_banked_mem.sv
// Directed bench for banked_mem: default 2-bank/lat-1 instance plus a
// 4-bank/64-word/lat-2 instance; collision expectation follows the macro.
module tb_banked_mem;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_wen, a_ren, a_rvalid;
  logic [3:0] a_addr;
  logic [7:0] a_wdata, a_rdata;

  logic       b_rst, b_wen, b_ren, b_rvalid;
  logic [5:0] b_addr;
  logic [7:0] b_wdata, b_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  banked_mem u_dut_a (
    .clk(clk), .rst(a_rst), .addr(a_addr), .wdata(a_wdata),
    .wen(a_wen), .ren(a_ren), .rdata(a_rdata), .rvalid(a_rvalid)
  );

  banked_mem #(.DATA_W(8), .ADDR_W(6), .NUM_BANKS(4), .READ_LAT(2)) u_dut_b (
    .clk(clk), .rst(b_rst), .addr(b_addr), .wdata(b_wdata),
    .wen(b_wen), .ren(b_ren), .rdata(b_rdata), .rvalid(b_rvalid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_wr(input logic [3:0] ad, input logic [7:0] d);
    a_wen = 1'b1; a_ren = 1'b0; a_addr = ad; a_wdata = d;
    tick();
    a_wen = 1'b0;
  endtask

  logic [7:0] exp_coll;
  int         pulses;
  bit         exp_v;

  initial begin
    a_rst = 1'b1; a_wen = 1'b0; a_ren = 1'b0; a_addr = '0; a_wdata = '0;
    b_rst = 1'b1; b_wen = 1'b0; b_ren = 1'b0; b_addr = '0; b_wdata = '0;
    tick(); tick();
    a_rst = 1'b0; b_rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_rvalid", 32'(a_rvalid), 32'd0);
      chk("idle_rdata",  32'(a_rdata),  32'd0);
    end
    chk("b_rst_rvalid", 32'(b_rvalid), 32'd0);
    chk("b_rst_rdata",  32'(b_rdata),  32'd0);

    // Bank-select alignment across back-to-back reads to different banks
    a_wr(4'h3, 8'hA5);
    a_wr(4'hB, 8'h5A);
    a_ren = 1'b1; a_addr = 4'h3;
    tick();
    chk("align0_rvalid", 32'(a_rvalid), 32'd1);
    chk("align0_rdata",  32'(a_rdata),  32'hA5);
    a_addr = 4'hB;
    tick();
    chk("align1_rvalid", 32'(a_rvalid), 32'd1);
    chk("align1_rdata",  32'(a_rdata),  32'h5A);
    a_ren = 1'b0;
    tick();
    chk("hold_rvalid", 32'(a_rvalid), 32'd0);
    chk("hold_rdata",  32'(a_rdata),  32'h5A);

    // Same-cycle write and read collision
    a_wr(4'h7, 8'h11);
`ifdef BANKED_MEM_WR_BYPASS_EN
    exp_coll = 8'h22;
`else
    exp_coll = 8'h11;
`endif
    a_wen = 1'b1; a_ren = 1'b1; a_addr = 4'h7; a_wdata = 8'h22;
    tick();
    chk("coll_rvalid", 32'(a_rvalid), 32'd1);
    chk("coll_rdata",  32'(a_rdata),  32'(exp_coll));
    a_wen = 1'b0;
    tick();
    chk("coll_follow", 32'(a_rdata), 32'h22);
    a_ren = 1'b0;

    // No cross-bank aliasing between 0x2 and 0xA
    a_wr(4'hA, 8'h00);
    a_wr(4'h2, 8'hFF);
    a_ren = 1'b1; a_addr = 4'hA;
    tick();
    chk("alias_a", 32'(a_rdata), 32'h00);
    a_addr = 4'h2;
    tick();
    chk("alias_2", 32'(a_rdata), 32'hFF);
    a_ren = 1'b0;

    // wen/ren coincident with rst are ignored
    a_rst = 1'b1; a_wen = 1'b1; a_ren = 1'b1; a_addr = 4'h3; a_wdata = 8'h77;
    tick();
    chk("rst_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_rdata",  32'(a_rdata),  32'd0);
    a_rst = 1'b0; a_wen = 1'b0; a_ren = 1'b0;
    tick();
    chk("rst_ren_dropped", 32'(a_rvalid), 32'd0);
    a_ren = 1'b1;
    tick();
    chk("rst_wen_ignored", 32'(a_rdata), 32'hA5);
    a_ren = 1'b0;

    // 4-bank fill then full streaming read sweep
    for (int i = 0; i < 64; i++) begin
      b_wen = 1'b1; b_addr = 6'(i); b_wdata = 8'(i) ^ 8'h3C;
      tick();
    end
    b_wen = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 66; k++) begin
      b_ren  = (k <= 64);
      b_addr = 6'(k - 1);
      tick();
      exp_v = (k >= 2) && (k <= 65);
      chk($sformatf("sweep_vld_%0d", k), 32'(b_rvalid), 32'(exp_v));
      if (exp_v) chk($sformatf("sweep_dat_%0d", k), 32'(b_rdata), 32'(8'(k - 2) ^ 8'h3C));
      if (b_rvalid) pulses++;
    end
    chk("sweep_pulses", 32'(pulses), 32'd64);

    // In-flight read squashed by reset at the next edge
    b_ren = 1'b1; b_addr = 6'h05;
    tick();
    chk("squash_issue", 32'(b_rvalid), 32'd0);
    b_ren = 1'b0; b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    chk("squash_rdata", 32'(b_rdata), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("squash_vld_%0d", i), 32'(b_rvalid), 32'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
